sbox_lane_pipe: RTL and testbench

- Parametrised successor to the single-byte registered SBox memory block.
- Performs LANES parallel AES S-box lookups per transaction, each lane a byte-wide ROM.
- Per-transaction forward/inverse mode select.
- Configurable pipeline depth with full valid/ready backpressure, so it can sit between streaming datapath stages in the memory-design test suite.

---
 rtl/sbox_lane_pipe.sv | 144 ++++++++++++++
 tb/tb_sbox_lane_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_lane_pipe.sv
// sbox_lane_pipe: performs LANES parallel AES S-box byte substitutions per
// transaction, with a forward/inverse select for each transaction. The data
// path is pipelined over 1 or 2 registered stages and uses valid/ready
// handshaking on both sides.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   valid_in   upstream transaction valid
//   ready_out  block can accept a transaction this cycle
//   inv_in     1 = inverse S-box for this transaction (only when INV_EN=1)
//   addr       input bytes, lane k = addr[8k+7:8k]
//   valid_out  dout holds a valid result
//   ready_in   downstream accepts the result this cycle
//   dout       substituted bytes, lane k from addr lane k
module sbox_lane_pipe #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int INV_EN      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic               inv_in,
  input  logic [8*LANES-1:0] addr,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [8*LANES-1:0] dout
);

  localparam int W = 8 * LANES;

  localparam logic [7:0] SBOX_FWD [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b, input logic inv);
    if ((INV_EN != 0) && inv) return SBOX_INV[b];
    return SBOX_FWD[b];
  endfunction

  function automatic logic [W-1:0] sbox_word(input logic [W-1:0] a, input logic inv);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) w[8*k +: 8] = sbox_byte(a[8*k +: 8], inv);
    return w;
  endfunction

  if (PIPE_STAGES == 1) begin : g_one
    logic         vld_p1;
    logic [W-1:0] sub_p1;

    assign ready_out = !vld_p1 || ready_in;
    assign valid_out = vld_p1;
    assign dout      = sub_p1;

    // p0 -> p1: lookup straight from the accepted input into the output register
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_p1 <= 1'b0;
        sub_p1 <= '0;
      end else if (ready_out) begin
        vld_p1 <= valid_in;
        if (valid_in) sub_p1 <= sbox_word(addr, inv_in);
      end
    end
  end else begin : g_two
    logic         vld_p1;
    logic [W-1:0] addr_p1;
    logic         inv_p1;
    logic         vld_p2;
    logic [W-1:0] sub_p2;
    logic         load_p2;

    // The output stage can take new content when empty or being drained;
    // stage 1 can then take new input when it is empty or moving forward.
    assign load_p2   = !vld_p2 || ready_in;
    assign ready_out = !vld_p1 || load_p2;
    assign valid_out = vld_p2;
    assign dout      = sub_p2;

    // p0 -> p1: capture addr and mode
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_p1  <= 1'b0;
        addr_p1 <= '0;
        inv_p1  <= 1'b0;
      end else if (ready_out) begin
        vld_p1 <= valid_in;
        if (valid_in) begin
          addr_p1 <= addr;
          inv_p1  <= inv_in;
        end
      end
    end

    // p1 -> p2: ROM lookup into the output register
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_p2 <= 1'b0;
        sub_p2 <= '0;
      end else if (load_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) sub_p2 <= sbox_word(addr_p1, inv_p1);
      end
    end
  end

endmodule

// File: tb/tb_sbox_lane_pipe.sv
module tb_sbox_lane_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic        inv_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [31:0] addr = '0;

  logic        ready_out_a, valid_out_a, ready_out_b, valid_out_b, ready_out_c, valid_out_c;
  logic [31:0] dout_a, dout_b, dout_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: 2 stages with inverse, b: 2 stages forward-only, c: 1 stage with inverse
  sbox_lane_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(1)) dut_a (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out_a), .inv_in(inv_in),
    .addr(addr), .valid_out(valid_out_a), .ready_in(ready_in), .dout(dout_a));
  sbox_lane_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(0)) dut_b (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out_b), .inv_in(inv_in),
    .addr(addr), .valid_out(valid_out_b), .ready_in(ready_in), .dout(dout_b));
  sbox_lane_pipe #(.LANES(4), .PIPE_STAGES(1), .INV_EN(1)) dut_c (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out_c), .inv_in(inv_in),
    .addr(addr), .valid_out(valid_out_c), .ready_in(ready_in), .dout(dout_c));

  // Golden S-box from GF(2^8) arithmetic: multiplicative inverse + affine map.
  logic [7:0] gf_s  [256];
  logic [7:0] gf_si [256];

  function automatic logic [7:0] gmul(input logic [7:0] xi, input logic [7:0] yi);
    logic [7:0] x, y, p;
    x = xi; y = yi; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb, b, s;
      xb = x[7:0];
      b = 8'h00;
      for (int y = 1; y < 256; y++) begin
        logic [7:0] yb;
        yb = y[7:0];
        if (xb != 8'h00 && gmul(xb, yb) == 8'h01) b = yb;
      end
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      gf_s[x] = s;
      gf_si[s] = xb;
    end
  endtask

  function automatic logic [31:0] gold_word(input logic [31:0] a, input logic inv, input bit inv_en);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = (inv && inv_en) ? gf_si[a[8*k +: 8]] : gf_s[a[8*k +: 8]];
    return r;
  endfunction

  // Transaction-level model: FIFO of accepted items with their acceptance edge.
  // A block of depth D holds at most D items; the oldest is presented D-1 edges
  // after the edge that accepted it.
  typedef struct { logic [31:0] a; logic [31:0] b; int t; } item_t;
  item_t qa[$];
  item_t qc[$];
  int    cyc = 0;

  function automatic bit exp_vo_a(); return qa.size() > 0 && (cyc - qa[0].t) >= 1; endfunction
  function automatic bit exp_rdy_a(); return qa.size() < 2 || ready_in; endfunction
  function automatic bit exp_vo_c(); return qc.size() > 0; endfunction
  function automatic bit exp_rdy_c(); return qc.size() < 1 || ready_in; endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qa.delete();
      qc.delete();
    end else begin
      bit out_a, in_a, out_c, in_c;
      out_a = exp_vo_a() && ready_in;
      in_a  = valid_in && exp_rdy_a();
      out_c = exp_vo_c() && ready_in;
      in_c  = valid_in && exp_rdy_c();
      cyc = cyc + 1;
      if (out_a) void'(qa.pop_front());
      if (in_a) qa.push_back('{gold_word(addr, inv_in, 1'b1), gold_word(addr, inv_in, 1'b0), cyc});
      if (out_c) void'(qc.pop_front());
      if (in_c) qc.push_back('{gold_word(addr, inv_in, 1'b1), 32'h0, cyc});
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0; ready_in = 1'b1;
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ready_in = 1'b1; valid_in = 1'b1; addr = 32'h12345678;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL reset_vo_a: got %b need 0", valid_out_a); end
    checks++; if (dout_a !== 32'h0) begin errors++; $display("FAIL reset_dout_a: got %h need 0", dout_a); end
    checks++; if (dout_b !== 32'h0) begin errors++; $display("FAIL reset_dout_b: got %h need 0", dout_b); end
    checks++; if (valid_out_c !== 1'b0 || dout_c !== 32'h0) begin errors++; $display("FAIL reset_c: got vo=%b dout=%h need 0/0", valid_out_c, dout_c); end
    valid_in = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (ready_out_a !== 1'b1) begin errors++; $display("FAIL reset_rdy_a: got %b need 1", ready_out_a); end
    checks++; if (ready_out_c !== 1'b1) begin errors++; $display("FAIL reset_rdy_c: got %b need 1", ready_out_c); end
  endtask

  task automatic single_beat(input string nm, input logic [31:0] a, input logic inv,
                             input logic [31:0] ea, input logic [31:0] eb);
    @(negedge clk);
    valid_in = 1'b1; addr = a; inv_in = inv; ready_in = 1'b1;
    #1;
    checks++; if (ready_out_a !== 1'b1) begin errors++; $display("FAIL %s_rdy: got %b need 1", nm, ready_out_a); end
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL %s_early_vo: got %b need 0", nm, valid_out_a); end
    checks++; if (valid_out_c !== 1'b1 || dout_c !== ea) begin errors++; $display("FAIL %s_c: got vo=%b dout=%h need 1/%h", nm, valid_out_c, dout_c, ea); end
    @(negedge clk); #1;
    checks++; if (valid_out_a !== 1'b1 || dout_a !== ea) begin errors++; $display("FAIL %s_a: got vo=%b dout=%h need 1/%h", nm, valid_out_a, dout_a, ea); end
    checks++; if (valid_out_b !== 1'b1 || dout_b !== eb) begin errors++; $display("FAIL %s_b: got vo=%b dout=%h need 1/%h", nm, valid_out_b, dout_b, eb); end
    @(negedge clk); #1;
    checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL %s_drain: got %b need 0", nm, valid_out_a); end
  endtask

  task automatic test_forward();
    single_beat("fwd", 32'hFF530100, 1'b0, 32'h16ED7C63, 32'h16ED7C63);
  endtask

  task automatic test_inverse();
    single_beat("inv", 32'h0063ED16, 1'b1, 32'h520053FF, 32'h63FB5547);
  endtask

  task automatic test_streaming();
    int outs = 0;
    idle(3);
    for (int i = 0; i < 262; i++) begin
      @(negedge clk);
      ready_in = 1'b1;
      if (i < 256) begin
        valid_in = 1'b1;
        addr = {$urandom_range(0, 32'hFFFFFF) & 32'hFFFFFF} << 8 | 32'(i);
        inv_in = i[0];
      end else valid_in = 1'b0;
      #1;
      if (i < 256) begin
        checks++; if (ready_out_a !== 1'b1) begin errors++; $display("FAIL stream_rdy[%0d]: got %b need 1", i, ready_out_a); end
      end
      checks++; if (valid_out_a !== exp_vo_a()) begin errors++; $display("FAIL stream_vo[%0d]: got %b need %b", i, valid_out_a, exp_vo_a()); end
      if (exp_vo_a()) begin
        checks++; if (dout_a !== qa[0].a) begin errors++; $display("FAIL stream_dout[%0d]: got %h need %h", i, dout_a, qa[0].a); end
      end
      if (valid_out_a === 1'b1) outs++;
    end
    checks++; if (outs != 256) begin errors++; $display("FAIL stream_count: got %0d need 256", outs); end
  endtask

  task automatic test_backpressure();
    int acc = 0, outs = 0;
    logic [31:0] held = '0;
    bit have_held = 0, take_new = 1;
    idle(3);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (take_new) begin addr = $urandom; inv_in = $urandom_range(0, 1); end
      valid_in = (acc < 6);
      ready_in = (k >= 5);
      #1;
      checks++; if (ready_out_a !== exp_rdy_a()) begin errors++; $display("FAIL bp_rdy[%0d]: got %b need %b", k, ready_out_a, exp_rdy_a()); end
      checks++; if (valid_out_a !== exp_vo_a()) begin errors++; $display("FAIL bp_vo[%0d]: got %b need %b", k, valid_out_a, exp_vo_a()); end
      if (exp_vo_a()) begin
        checks++; if (dout_a !== qa[0].a) begin errors++; $display("FAIL bp_dout[%0d]: got %h need %h", k, dout_a, qa[0].a); end
      end
      if (k < 5 && valid_out_a === 1'b1) begin
        if (!have_held) begin held = dout_a; have_held = 1; end
        else begin
          checks++; if (dout_a !== held) begin errors++; $display("FAIL bp_hold[%0d]: got %h need %h", k, dout_a, held); end
        end
      end
      if (k == 4) begin
        checks++; if (acc != 2 || ready_out_a !== 1'b0) begin errors++; $display("FAIL bp_full: got acc=%0d rdy=%b need 2/0", acc, ready_out_a); end
      end
      take_new = valid_in && exp_rdy_a();
      if (take_new) acc++;
      if (valid_out_a === 1'b1 && ready_in) outs++;
    end
    checks++; if (outs != 6 || qa.size() != 0) begin errors++; $display("FAIL bp_count: got outs=%0d left=%0d need 6/0", outs, qa.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] x;
    idle(3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      valid_in = 1'b1; ready_in = 1'b0; addr = $urandom; inv_in = 1'b0;
      #1;
    end
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    checks++; if (valid_out_a !== 1'b1) begin errors++; $display("FAIL rmid_pre_vo: got %b need 1", valid_out_a); end
    #1 reset = 1'b0;
    #1;
    checks++; if (valid_out_a !== 1'b0 || dout_a !== 32'h0) begin errors++; $display("FAIL rmid_a: got vo=%b dout=%h need 0/0", valid_out_a, dout_a); end
    checks++; if (valid_out_c !== 1'b0 || dout_b !== 32'h0) begin errors++; $display("FAIL rmid_bc: got vo_c=%b dout_b=%h need 0/0", valid_out_c, dout_b); end
    @(negedge clk);
    reset = 1'b1; ready_in = 1'b1;
    #1;
    checks++; if (ready_out_a !== 1'b1 || valid_out_a !== 1'b0) begin errors++; $display("FAIL rmid_post: got rdy=%b vo=%b need 1/0", ready_out_a, valid_out_a); end
    x = 32'hA5C3_0F7E;
    @(negedge clk);
    valid_in = 1'b1; addr = x; inv_in = 1'b1;
    #1;
    checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL rmid_stale0: got %b need 0", valid_out_a); end
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL rmid_stale1: got %b need 0", valid_out_a); end
    @(negedge clk); #1;
    checks++; if (valid_out_a !== 1'b1 || dout_a !== gold_word(x, 1'b1, 1'b1)) begin
      errors++; $display("FAIL rmid_first: got vo=%b dout=%h need 1/%h", valid_out_a, dout_a, gold_word(x, 1'b1, 1'b1));
    end
  endtask

  task automatic test_random();
    idle(4);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      valid_in = $urandom_range(0, 1); ready_in = $urandom_range(0, 3) != 0;
      inv_in = $urandom_range(0, 1); addr = $urandom;
      #1;
      checks++; if (valid_out_a !== exp_vo_a() || ready_out_a !== exp_rdy_a()) begin
        errors++; $display("FAIL rnd_a_hs[%0d]: got vo=%b rdy=%b need %b/%b", i, valid_out_a, ready_out_a, exp_vo_a(), exp_rdy_a());
      end
      checks++; if (valid_out_b !== exp_vo_a() || ready_out_b !== exp_rdy_a()) begin
        errors++; $display("FAIL rnd_b_hs[%0d]: got vo=%b rdy=%b need %b/%b", i, valid_out_b, ready_out_b, exp_vo_a(), exp_rdy_a());
      end
      checks++; if (valid_out_c !== exp_vo_c() || ready_out_c !== exp_rdy_c()) begin
        errors++; $display("FAIL rnd_c_hs[%0d]: got vo=%b rdy=%b need %b/%b", i, valid_out_c, ready_out_c, exp_vo_c(), exp_rdy_c());
      end
      if (exp_vo_a()) begin
        checks++; if (dout_a !== qa[0].a) begin errors++; $display("FAIL rnd_a_dout[%0d]: got %h need %h", i, dout_a, qa[0].a); end
        checks++; if (dout_b !== qa[0].b) begin errors++; $display("FAIL rnd_b_dout[%0d]: got %h need %h", i, dout_b, qa[0].b); end
      end
      if (exp_vo_c()) begin
        checks++; if (dout_c !== qc[0].a) begin errors++; $display("FAIL rnd_c_dout[%0d]: got %h need %h", i, dout_c, qc[0].a); end
      end
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_forward();
    test_inverse();
    test_streaming();
    test_backpressure();
    test_reset_mid();
    test_random();
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
